blake2_g_seq: RTL and testbench
===============================

BLAKE2_G_SEQ -- requirements
Module: blake2_g_seq

Interface
REQ-001 Parameter WORD_W, default 64: word width in bits; legal values 32 (BLAKE2s) and 64 (BLAKE2b).
REQ-002 Parameters R1, R2, R3, R4, defaults 32, 24, 16, 63: right-rotate distances for quarter-steps 0-3; each value is 1..WORD_W-1.
REQ-003 Parameter UNROLL, default 1: quarter-steps evaluated per cycle; legal values 1, 2, 4.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  the a/b/c/d/m0/m1 operand set is valid.
REQ-007 in_ready  output  1  the block accepts an operand set this cycle.
REQ-008 a, b, c, d, m0, m1  input  WORD_W each  G state words and message words.
REQ-009 out_valid  output  1  a_prim..d_prim hold a completed result.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 a_prim, b_prim, c_prim, d_prim  output  WORD_W each  registered G result.

Function
REQ-012 The FSM SHALL have three states, IDLE, BUSY and DONE; in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-013 IDLE: when in_valid=1, the block SHALL capture all six inputs into internal registers, clear the step counter to 0 and go to BUSY; otherwise it stays in IDLE.
REQ-014 Quarter-step 0 SHALL compute a=a+b+m0, then d=rotr(d^a,R1).
REQ-015 Quarter-step 1 SHALL compute c=c+d, then b=rotr(b^c,R2).
REQ-016 Quarter-step 2 SHALL compute a=a+b+m1, then d=rotr(d^a,R3).
REQ-017 Quarter-step 3 SHALL compute c=c+d, then b=rotr(b^c,R4).
REQ-018 Arithmetic SHALL be addition modulo 2^WORD_W: carries are discarded and no width growth is kept.
REQ-019 BUSY SHALL apply UNROLL consecutive quarter-steps per cycle, in order, and advance the step counter by UNROLL.
REQ-020 When the counter reaches 4, the block SHALL load a_prim..d_prim from the working registers and enter DONE.
REQ-021 Latency from the accept edge to the first cycle with out_valid=1 SHALL be 4/UNROLL cycles: 4, 2 or 1.
REQ-022 In DONE, a_prim..d_prim and out_valid SHALL hold stable until out_ready=1; on that edge the block returns to IDLE.
REQ-023 in_ready SHALL be 0 in DONE, so no operand set is accepted on the cycle a result is released; maximum throughput is one G per 4/UNROLL+2 cycles.
REQ-024 The block SHALL ignore inputs while in BUSY or DONE, and input changes in those states SHALL NOT affect the result.
REQ-025 a_prim..d_prim SHALL change only on entry to DONE.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, step counter 0, all working registers 0, a_prim..d_prim 0, out_valid 0 and in_ready 1, independent of clk.
REQ-027 Reset asserted during BUSY or DONE SHALL abort the operation and discard its result; no out_valid pulse follows the release of reset.
REQ-028 in_valid=1 on the first edge after reset release SHALL be accepted normally.

Verification
REQ-029 Zero vector, WORD_W=64, UNROLL=1: all inputs 0 -> exactly 4 cycles after accept, out_valid=1 and all outputs 0.
REQ-030 BLAKE2s, WORD_W=32, R=16/12/8/7, UNROLL=1: a=b=c=d=0, m0=1, m1=0 -> a_prim=0x00000011, b_prim=0x20220202, c_prim=0x11010100, d_prim=0x11000100 after 4 cycles.
REQ-031 The REQ-030 vector with UNROLL=2 and with UNROLL=4 -> identical outputs after 2 and 1 cycles respectively.
REQ-032 Back-pressure: hold out_ready=0 for 10 cycles in DONE while driving new in_valid/operands -> outputs stable, in_ready=0, nothing captured; out_ready=1 -> IDLE next cycle.
REQ-033 Reset pulse mid-BUSY (WORD_W=64, step 2) -> all outputs 0 at once, no out_valid after release, and the next accepted vector gives its correct result.
REQ-034 Randomised run: 10k vectors per (WORD_W, UNROLL) combination, checked against a reference model of REQ-014..REQ-018, with random in_valid/out_ready gaps -> zero mismatches and no lost or duplicated results.

Source files
------------

// File: rtl/blake2_g_seq.sv
// Sequential BLAKE2 G function: one G evaluation spread over 4/UNROLL cycles, with a
// valid/ready handshake on both the operand side and the result side.
module blake2_g_seq #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned R1     = 32,
    parameter int unsigned R2     = 24,
    parameter int unsigned R3     = 16,
    parameter int unsigned R4     = 63,
    parameter int unsigned UNROLL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    input  logic [WORD_W-1:0] m0,
    input  logic [WORD_W-1:0] m1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] a_prim,
    output logic [WORD_W-1:0] b_prim,
    output logic [WORD_W-1:0] c_prim,
    output logic [WORD_W-1:0] d_prim
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] STEP_INC = 3'(UNROLL);

    logic [1:0]        state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [WORD_W-1:0] wa_q, wb_q, wc_q, wd_q, wm0_q, wm1_q;
    logic [WORD_W-1:0] a_prim_q, b_prim_q, c_prim_q, d_prim_q;
    logic [WORD_W-1:0] na, nb, nc, nd;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        rotr = (x >> n) | (x << (WORD_W - n));
    endfunction

    // Working words after this cycle's UNROLL quarter-steps, starting at step_q.
    always_comb begin
        na = wa_q;
        nb = wb_q;
        nc = wc_q;
        nd = wd_q;
        for (int i = 0; i < int'(UNROLL); i++) begin
            unique case (step_q[1:0] + 2'(i))
                2'd0: begin
                    na = na + nb + wm0_q;
                    nd = rotr(nd ^ na, R1);
                end
                2'd1: begin
                    nc = nc + nd;
                    nb = rotr(nb ^ nc, R2);
                end
                2'd2: begin
                    na = na + nb + wm1_q;
                    nd = rotr(nd ^ na, R3);
                end
                2'd3: begin
                    nc = nc + nd;
                    nb = rotr(nb ^ nc, R4);
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    step_d  = 3'd0;
                end
            end
            BUSY: begin
                step_d = step_q + STEP_INC;
                if (step_d == 3'd4) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= 3'd0;
            wa_q     <= '0;
            wb_q     <= '0;
            wc_q     <= '0;
            wd_q     <= '0;
            wm0_q    <= '0;
            wm1_q    <= '0;
            a_prim_q <= '0;
            b_prim_q <= '0;
            c_prim_q <= '0;
            d_prim_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (state_q == IDLE && in_valid) begin
                wa_q  <= a;
                wb_q  <= b;
                wc_q  <= c;
                wd_q  <= d;
                wm0_q <= m0;
                wm1_q <= m1;
            end else if (state_q == BUSY) begin
                wa_q <= na;
                wb_q <= nb;
                wc_q <= nc;
                wd_q <= nd;
            end
            // Results are published straight from the final quarter-step's logic.
            if (state_q == BUSY && state_d == DONE) begin
                a_prim_q <= na;
                b_prim_q <= nb;
                c_prim_q <= nc;
                d_prim_q <= nd;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign a_prim    = a_prim_q;
    assign b_prim    = b_prim_q;
    assign c_prim    = c_prim_q;
    assign d_prim    = d_prim_q;

endmodule

// File: tb/tb_blake2_g_seq.sv
// Scoreboard bench for blake2_g_seq: four instances (32-bit x UNROLL 1/2/4, 64-bit x UNROLL 1)
// share one operand bus; each has its own out_ready and result monitor.
module tb_blake2_g_seq;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] d;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] a_in, b_in, c_in, d_in, m0_in, m1_in;
    logic [3:0]  in_ready, out_valid, out_ready;
    logic [63:0] a_out [4];
    logic [63:0] b_out [4];
    logic [63:0] c_out [4];
    logic [63:0] d_out [4];

    res_t exp_q [4][$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   rdy_mode = 2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_v(input int k, input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got %h, expected %h", k, nm, act, exp);
        end
    endtask

    task automatic chk_r(input int k, input string nm, input res_t act, input res_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got %h, expected %h", k, nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int w);
        if (w == 32) return {32'd0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic res_t gmodel(input logic [63:0] ia, ib, ic, id, im0, im1, input int w);
        logic [63:0] msk, va, vb, vc, vd, vm0, vm1;
        int r0, r1, r2, r3;
        msk = (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
        if (w == 32) begin r0 = 16; r1 = 12; r2 = 8;  r3 = 7;  end
        else         begin r0 = 32; r1 = 24; r2 = 16; r3 = 63; end
        va = ia & msk; vb = ib & msk; vc = ic & msk; vd = id & msk;
        vm0 = im0 & msk; vm1 = im1 & msk;
        va = (va + vb + vm0) & msk; vd = rot(vd ^ va, r0, w);
        vc = (vc + vd) & msk;       vb = rot(vb ^ vc, r1, w);
        va = (va + vb + vm1) & msk; vd = rot(vd ^ va, r2, w);
        vc = (vc + vd) & msk;       vb = rot(vb ^ vc, r3, w);
        return {va, vb, vc, vd};
    endfunction

    generate
        for (genvar k = 0; k < 4; k++) begin : g_dut
            localparam int unsigned W  = (k == 3) ? 64 : 32;
            localparam int unsigned U  = (k == 1) ? 2 : (k == 2) ? 4 : 1;
            localparam int unsigned RA = (k == 3) ? 32 : 16;
            localparam int unsigned RB = (k == 3) ? 24 : 12;
            localparam int unsigned RC = (k == 3) ? 16 : 8;
            localparam int unsigned RD = (k == 3) ? 63 : 7;
            logic [W-1:0] ap, bp, cp, dp;
            logic         ir, ov;

            blake2_g_seq #(
                .WORD_W(W), .R1(RA), .R2(RB), .R3(RC), .R4(RD), .UNROLL(U)
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .in_valid (in_valid),
                .in_ready (ir),
                .a        (a_in[W-1:0]),
                .b        (b_in[W-1:0]),
                .c        (c_in[W-1:0]),
                .d        (d_in[W-1:0]),
                .m0       (m0_in[W-1:0]),
                .m1       (m1_in[W-1:0]),
                .out_valid(ov),
                .out_ready(out_ready[k]),
                .a_prim   (ap),
                .b_prim   (bp),
                .c_prim   (cp),
                .d_prim   (dp)
            );

            assign in_ready[k]  = ir;
            assign out_valid[k] = ov;
            assign a_out[k]     = 64'(ap);
            assign b_out[k]     = 64'(bp);
            assign c_out[k]     = 64'(cp);
            assign d_out[k]     = 64'(dp);

            // Result monitor: latency, hold stability, idle stability and scoreboard pop.
            initial begin
                res_t got, last, held_v, e;
                logic held, ov_prev;
                int   acc_cyc;
                last = '0; held_v = '0; held = 1'b0; ov_prev = 1'b0; acc_cyc = 0;
                forever begin
                    @(negedge clk);
                    got = {a_out[k], b_out[k], c_out[k], d_out[k]};
                    if (reset) begin
                        last = '0; held = 1'b0; ov_prev = 1'b0;
                    end else begin
                        if (in_valid && in_ready[k]) acc_cyc = cyc + 1;
                        if (out_valid[k]) begin
                            chk_v(k, "in_ready_in_done", 64'(in_ready[k]), 64'd0);
                            if (!ov_prev) chk_v(k, "latency", 64'(cyc - acc_cyc), 64'(4 / U));
                            if (held) chk_r(k, "hold_stable", got, held_v);
                            if (out_ready[k]) begin
                                if (exp_q[k].size() == 0) begin
                                    checks++;
                                    errors++;
                                    $display("FAIL u%0d unexpected_result: got %h, expected none",
                                             k, got);
                                end else begin
                                    e = exp_q[k].pop_front();
                                    chk_r(k, "result", got, e);
                                end
                                held = 1'b0;
                            end else begin
                                held   = 1'b1;
                                held_v = got;
                            end
                            last = got;
                        end else begin
                            held = 1'b0;
                            chk_r(k, "outputs_change_only_on_done", got, last);
                        end
                        ov_prev = out_valid[k];
                    end
                end
            end
        end
    endgenerate

    // out_ready pattern: 0 = held low, 1 = random, 2 = held high, 3 = driven by main process.
    initial begin
        out_ready = 4'hf;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 4'h0;
                1: out_ready = 4'($urandom_range(0, 15));
                2: out_ready = 4'hf;
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic junk_ops();
        a_in  = {$urandom, $urandom}; b_in  = {$urandom, $urandom};
        c_in  = {$urandom, $urandom}; d_in  = {$urandom, $urandom};
        m0_in = {$urandom, $urandom}; m1_in = {$urandom, $urandom};
    endtask

    task automatic issue(input logic [63:0] va, vb, vc, vd, vm0, vm1, input res_t hand,
                         input bit use_hand);
        int n;
        n = 0;
        while (in_ready != 4'hf) begin
            step();
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_wait: got in_ready %b, expected 1111 within 200 cycles",
                         in_ready);
                return;
            end
        end
        in_valid = 1'b1;
        a_in = va; b_in = vb; c_in = vc; d_in = vd; m0_in = vm0; m1_in = vm1;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].push_back(use_hand ? hand : gmodel(va, vb, vc, vd, vm0, vm1, 32));
        end
        exp_q[3].push_back(gmodel(va, vb, vc, vd, vm0, vm1, 64));
        step();
        in_valid = 1'b0;
        junk_ops();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0) begin
            step();
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL drain: got %0d results outstanding, expected 0", exp_q[0].size()
                         + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
                return;
            end
        end
        repeat (2) step();
    endtask

    task automatic chk_reset_state(input string nm);
        for (int k = 0; k < 4; k++) begin
            chk_v(k, {nm, "_in_ready"}, 64'(in_ready[k]), 64'd1);
            chk_v(k, {nm, "_out_valid"}, 64'(out_valid[k]), 64'd0);
            chk_r(k, {nm, "_outputs"}, {a_out[k], b_out[k], c_out[k], d_out[k]}, '0);
        end
    endtask

    initial begin
        logic [63:0] z, one;
        z = 64'h0; one = 64'h1;
        reset = 1'b1; in_valid = 1'b0;
        a_in = z; b_in = z; c_in = z; d_in = z; m0_in = z; m1_in = z;
        #1;
        chk_reset_state("reset");
        repeat (2) @(posedge clk);
        step();
        reset = 1'b0;

        // Directed vectors (first one lands on the first edge after reset release).
        issue(z, z, z, z, z, z, '0, 1'b1);
        issue(z, z, z, z, one, z,
              {64'h11, 64'h20220202, 64'h11010100, 64'h11000100}, 1'b1);
        issue(one, z, z, z, z, z,
              {64'h11, 64'h20220202, 64'h11010100, 64'h11000100}, 1'b1);
        issue(z, one, z, z, z, z,
              {64'h00100011, 64'h20222222, 64'h11011100, 64'h11001100}, 1'b1);
        issue(z, z, z, one, z, z,
              {64'h10, 64'h20200202, 64'h10010100, 64'h10000100}, 1'b1);
        issue(z, z, z, z, z, one,
              {64'h1, 64'h00020000, 64'h01000000, 64'h01000000}, 1'b1);
        issue(64'hffff_ffff, z, z, z, one, z, '0, 1'b1);
        drain();

        // Random operands with random issue gaps and random back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) step();
            issue({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b0);
        end
        rdy_mode = 2;
        drain();

        // Back-pressure: all instances sit in DONE while new operands are offered.
        rdy_mode = 3;
        out_ready = 4'h0;
        issue(z, one, z, z, z, z,
              {64'h00100011, 64'h20222222, 64'h11011100, 64'h11001100}, 1'b1);
        repeat (5) step();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            junk_ops();
            step();
            chk_v(0, "bp_in_ready", 64'(in_ready), 64'd0);
            chk_v(0, "bp_out_valid", 64'(out_valid), 64'hf);
        end
        in_valid  = 1'b0;
        out_ready = 4'hf;
        step();
        chk_v(0, "bp_release_idle", 64'(in_ready), 64'hf);
        rdy_mode = 2;
        drain();

        // Reset pulse while the 64-bit UNROLL=1 instance is at step 2.
        rdy_mode = 3;
        out_ready = 4'h0;
        issue({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1'b0);
        step();
        step();
        reset = 1'b1;
        #1;
        chk_reset_state("mid_busy_reset");
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        step();
        step();
        reset = 1'b0;
        out_ready = 4'hf;
        rdy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_v(0, "no_valid_after_reset", 64'(out_valid), 64'd0);
        end
        issue(z, z, z, z, one, z,
              {64'h11, 64'h20220202, 64'h11010100, 64'h11000100}, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
